// File: rtl/debug_port.sv
// Host debug register port: synchronised host strobes, opcode/address/data registers,
// core capture register and memory address counter. Optional STATUS read via DEBUG_STATUS_REG_EN.
`timescale 1ns/1ps
module debug_port (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  DEBUG_DIN,
  output logic [7:0]  DEBUG_DOUT,
  input  logic [2:0]  DEBUG_ADDR,
  input  logic        DEBUG_RD,
  input  logic        DEBUG_WR,
  output logic [15:0] DEBUG_MEM_ADDR,
  output logic [15:0] DEBUG_MEM_DATA_OUT,
  input  logic        DEBUG_ADDR_INCX,
  input  logic        DEBUG_ADDR_LDX,
  input  logic        DEBUG_DOUT_LDX,
  input  logic [1:0]  DEBUG_DATAX,
  output logic [2:0]  DEBUG_OPX,
  output logic [3:0]  DEBUG_ARGX,
  input  logic [15:0] DEBUG_DIN_DIN,
  input  logic [15:0] DEBUG_REGB_DATA,
  input  logic [15:0] DEBUG_CC_DATA,
  input  logic [15:0] DEBUG_PC_A_NEXT,
  output logic        DEBUG_REQX,
  input  logic        DEBUG_ACKX
);

  localparam logic [2:0] OP_NONE   = 3'd0;
  localparam logic [2:0] A_OPX     = 3'd0;
  localparam logic [2:0] A_MAL     = 3'd1;
  localparam logic [2:0] A_MAH     = 3'd2;
  localparam logic [2:0] A_MDL     = 3'd3;
  localparam logic [2:0] A_MDH     = 3'd4;
  localparam logic [2:0] A_STATUS  = 3'd5;

  // Index 0 = WR strobe, index 1 = RD strobe
  logic [1:0] w_strobe;
  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic [1:0] r_dly;
  logic [1:0] w_fire;

  assign w_strobe = {DEBUG_RD, DEBUG_WR};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          r_meta[gi] <= 1'b0;
          r_sync[gi] <= 1'b0;
          r_dly[gi]  <= 1'b0;
        end else begin
          r_meta[gi] <= w_strobe[gi];
          r_sync[gi] <= r_meta[gi];
          r_dly[gi]  <= r_sync[gi];
        end
      end
      assign w_fire[gi] = r_dly[gi] & ~r_sync[gi];
    end
  endgenerate

  logic       w_wr_fire;
  logic       w_rd_fire;
  assign w_wr_fire = w_fire[0];
  assign w_rd_fire = w_fire[1];

  logic [7:0]  r_mal;
  logic [7:0]  r_mah;
  logic [7:0]  r_mdl;
  logic [7:0]  r_mdh;
  logic [2:0]  r_opx;
  logic [3:0]  r_argx;
  logic        r_reqx;
  logic [15:0] r_cap;
  logic [15:0] r_mem_addr;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_mal  <= 8'h00;
      r_mah  <= 8'h00;
      r_mdl  <= 8'h00;
      r_mdh  <= 8'h00;
      r_opx  <= OP_NONE;
      r_argx <= 4'h0;
    end else if (w_wr_fire) begin
      case (DEBUG_ADDR)
        A_OPX: begin
          r_opx  <= DEBUG_DIN[2:0];
          r_argx <= DEBUG_DIN[7:4];
        end
        A_MAL:   r_mal <= DEBUG_DIN;
        A_MAH:   r_mah <= DEBUG_DIN;
        A_MDL:   r_mdl <= DEBUG_DIN;
        A_MDH:   r_mdh <= DEBUG_DIN;
        default: ;
      endcase
    end
  end

  // A new request (opcode write or streamed MDH read) outranks a same-cycle acknowledge.
  logic w_req_set;
  assign w_req_set = (w_wr_fire && (DEBUG_ADDR == A_OPX) && (DEBUG_DIN[2:0] != OP_NONE)) ||
                     (w_rd_fire && (DEBUG_ADDR == A_MDH) && (r_opx != OP_NONE));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_reqx <= 1'b0;
    end else if (w_req_set) begin
      r_reqx <= 1'b1;
    end else if (DEBUG_ACKX) begin
      r_reqx <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cap <= 16'h0000;
    end else if (DEBUG_DOUT_LDX) begin
      case (DEBUG_DATAX)
        2'd0:    r_cap <= DEBUG_DIN_DIN;
        2'd1:    r_cap <= DEBUG_REGB_DATA;
        2'd2:    r_cap <= DEBUG_CC_DATA;
        default: r_cap <= DEBUG_PC_A_NEXT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_mem_addr <= 16'h0000;
    end else if (DEBUG_ADDR_LDX) begin
      r_mem_addr <= {r_mah, r_mal};
    end else if (DEBUG_ADDR_INCX) begin
      r_mem_addr <= r_mem_addr + 16'd2;
    end
  end

  logic [7:0] w_status;
`ifdef DEBUG_STATUS_REG_EN
  assign w_status = {r_reqx, 4'b0000, r_opx};
`else
  assign w_status = 8'h00;
`endif

  logic [7:0] w_dout;
  always_comb begin
    w_dout = 8'h00;
    if (DEBUG_RD) begin
      case (DEBUG_ADDR)
        A_OPX:    w_dout = {r_argx, 1'b0, r_opx};
        A_MAL:    w_dout = r_mal;
        A_MAH:    w_dout = r_mah;
        A_MDL:    w_dout = r_cap[7:0];
        A_MDH:    w_dout = r_cap[15:8];
        A_STATUS: w_dout = w_status;
        default:  w_dout = 8'h00;
      endcase
    end
  end

  // DIN[3] has no register behind it.
  logic w_unused;
  assign w_unused = DEBUG_DIN[3];

  assign DEBUG_DOUT         = w_dout;
  assign DEBUG_MEM_ADDR     = r_mem_addr;
  assign DEBUG_MEM_DATA_OUT = {r_mdh, r_mdl};
  assign DEBUG_OPX          = r_opx;
  assign DEBUG_ARGX         = r_argx;
  assign DEBUG_REQX         = r_reqx;

endmodule

// File: tb/tb_debug_port.sv
`timescale 1ns/1ps
module tb_debug_port;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  DEBUG_DIN;
  logic [7:0]  DEBUG_DOUT;
  logic [2:0]  DEBUG_ADDR;
  logic        DEBUG_RD;
  logic        DEBUG_WR;
  logic [15:0] DEBUG_MEM_ADDR;
  logic [15:0] DEBUG_MEM_DATA_OUT;
  logic        DEBUG_ADDR_INCX;
  logic        DEBUG_ADDR_LDX;
  logic        DEBUG_DOUT_LDX;
  logic [1:0]  DEBUG_DATAX;
  logic [2:0]  DEBUG_OPX;
  logic [3:0]  DEBUG_ARGX;
  logic [15:0] DEBUG_DIN_DIN;
  logic [15:0] DEBUG_REGB_DATA;
  logic [15:0] DEBUG_CC_DATA;
  logic [15:0] DEBUG_PC_A_NEXT;
  logic        DEBUG_REQX;
  logic        DEBUG_ACKX;

  always #5 CLK = ~CLK;

  debug_port dut (
    .CLK(CLK), .RESET(RESET),
    .DEBUG_DIN(DEBUG_DIN), .DEBUG_DOUT(DEBUG_DOUT), .DEBUG_ADDR(DEBUG_ADDR),
    .DEBUG_RD(DEBUG_RD), .DEBUG_WR(DEBUG_WR),
    .DEBUG_MEM_ADDR(DEBUG_MEM_ADDR), .DEBUG_MEM_DATA_OUT(DEBUG_MEM_DATA_OUT),
    .DEBUG_ADDR_INCX(DEBUG_ADDR_INCX), .DEBUG_ADDR_LDX(DEBUG_ADDR_LDX),
    .DEBUG_DOUT_LDX(DEBUG_DOUT_LDX), .DEBUG_DATAX(DEBUG_DATAX),
    .DEBUG_OPX(DEBUG_OPX), .DEBUG_ARGX(DEBUG_ARGX),
    .DEBUG_DIN_DIN(DEBUG_DIN_DIN), .DEBUG_REGB_DATA(DEBUG_REGB_DATA),
    .DEBUG_CC_DATA(DEBUG_CC_DATA), .DEBUG_PC_A_NEXT(DEBUG_PC_A_NEXT),
    .DEBUG_REQX(DEBUG_REQX), .DEBUG_ACKX(DEBUG_ACKX)
  );

  localparam int K_DOUT = 0, K_MADDR = 1, K_MDATA = 2, K_OPX = 3, K_ARGX = 4, K_REQ = 5;

  typedef struct {
    string       name;
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [7:0]  m_mal, m_mah, m_mdl, m_mdh;
  logic [2:0]  m_opx;
  logic [3:0]  m_argx;
  logic        m_req;
  logic [15:0] m_cap, m_addr;
  logic [15:0] m_src [4];

  function automatic logic [15:0] actual(input int kind);
    case (kind)
      K_DOUT:  return {8'h00, DEBUG_DOUT};
      K_MADDR: return DEBUG_MEM_ADDR;
      K_MDATA: return DEBUG_MEM_DATA_OUT;
      K_OPX:   return {13'h0, DEBUG_OPX};
      K_ARGX:  return {12'h0, DEBUG_ARGX};
      default: return {15'h0, DEBUG_REQX};
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge CLK);
      while (q.size() > 0) begin
        exp_t e;
        logic [15:0] a;
        e = q.pop_front();
        a = actual(e.kind);
        checks++;
        if (a !== e.val) begin
          errors++;
          $display("FAIL %s actual=%h required=%h", e.name, a, e.val);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic push(input string nm, input int kind, input logic [15:0] v);
    exp_t e;
    e.name = nm; e.kind = kind; e.val = v;
    q.push_back(e);
  endtask

  task automatic sync_check();
    @(negedge CLK);
    @(posedge CLK); #1;
  endtask

  function automatic logic [7:0] model_dout(input logic [2:0] a);
    case (a)
      3'd0: return {m_argx, 1'b0, m_opx};
      3'd1: return m_mal;
      3'd2: return m_mah;
      3'd3: return m_cap[7:0];
      3'd4: return m_cap[15:8];
`ifdef DEBUG_STATUS_REG_EN
      3'd5: return {m_req, 4'b0000, m_opx};
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_mal = 0; m_mah = 0; m_mdl = 0; m_mdh = 0;
    m_opx = 0; m_argx = 0; m_req = 0; m_cap = 0; m_addr = 0;
  endtask

  task automatic model_write(input logic [2:0] a, input logic [7:0] d);
    case (a)
      3'd0: begin
        m_opx = d[2:0]; m_argx = d[7:4];
        if (d[2:0] != 3'd0) m_req = 1'b1;
      end
      3'd1: m_mal = d;
      3'd2: m_mah = d;
      3'd3: m_mdl = d;
      3'd4: m_mdh = d;
      default: ;
    endcase
  endtask

  task automatic expect_state(input string tag);
    push({tag, "_mem_addr"}, K_MADDR, m_addr);
    push({tag, "_mem_data"}, K_MDATA, {m_mdh, m_mdl});
    push({tag, "_opx"}, K_OPX, {13'h0, m_opx});
    push({tag, "_argx"}, K_ARGX, {12'h0, m_argx});
    push({tag, "_reqx"}, K_REQ, {15'h0, m_req});
    push({tag, "_dout_idle"}, K_DOUT, 16'h0000);
    sync_check();
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    DEBUG_ADDR = a; DEBUG_DIN = d; DEBUG_WR = 1'b1;
    repeat (3) @(posedge CLK);
    #1 DEBUG_WR = 1'b0;
    repeat (4) @(posedge CLK);
    #1 model_write(a, d);
  endtask

  task automatic host_write_ack(input logic [2:0] a, input logic [7:0] d);
    DEBUG_ADDR = a; DEBUG_DIN = d; DEBUG_WR = 1'b1;
    repeat (3) @(posedge CLK);
    #1 DEBUG_WR = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    DEBUG_ACKX = 1'b1;
    @(posedge CLK); #1;
    DEBUG_ACKX = 1'b0;
    model_write(a, d);
    @(posedge CLK); #1;
  endtask

  task automatic host_read(input logic [2:0] a, input string nm);
    logic old_req;
    DEBUG_ADDR = a; DEBUG_RD = 1'b1;
    #1 push(nm, K_DOUT, {8'h00, model_dout(a)});
    @(negedge CLK);
    @(posedge CLK); #1;
    DEBUG_RD = 1'b0;
    old_req = m_req;
    if (a == 3'd4 && m_opx != 3'd0) m_req = 1'b1;
    @(posedge CLK); #1;
    push({nm, "_reqx_1clk"}, K_REQ, {15'h0, old_req});
    @(negedge CLK);
    @(posedge CLK);
    @(posedge CLK); #1;
    push({nm, "_reqx_3clk"}, K_REQ, {15'h0, m_req});
    sync_check();
  endtask

  task automatic core_pulse(input logic ld, input logic ack, input logic [1:0] sel);
    DEBUG_DATAX = sel; DEBUG_DOUT_LDX = ld; DEBUG_ACKX = ack;
    @(posedge CLK); #1;
    DEBUG_DOUT_LDX = 1'b0; DEBUG_ACKX = 1'b0;
    if (ld) m_cap = m_src[sel];
    if (ack) m_req = 1'b0;
  endtask

  task automatic counter_pulse(input logic ld, input logic inc);
    DEBUG_ADDR_LDX = ld; DEBUG_ADDR_INCX = inc;
    @(posedge CLK); #1;
    DEBUG_ADDR_LDX = 1'b0; DEBUG_ADDR_INCX = 1'b0;
    if (ld) m_addr = {m_mah, m_mal};
    else if (inc) m_addr = m_addr + 16'd2;
  endtask

  task automatic set_sources(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
    DEBUG_DIN_DIN = a; DEBUG_REGB_DATA = b; DEBUG_CC_DATA = c; DEBUG_PC_A_NEXT = d;
    m_src[0] = a; m_src[1] = b; m_src[2] = c; m_src[3] = d;
  endtask

  initial begin
    RESET = 1'b0;
    DEBUG_DIN = 0; DEBUG_ADDR = 0; DEBUG_RD = 0; DEBUG_WR = 0;
    DEBUG_ADDR_INCX = 0; DEBUG_ADDR_LDX = 0; DEBUG_DOUT_LDX = 0;
    DEBUG_DATAX = 0; DEBUG_ACKX = 0;
    set_sources(16'h0, 16'h0, 16'h0, 16'h0);
    model_reset();
    repeat (3) @(posedge CLK);
    #1 expect_state("in_reset");
    RESET = 1'b1;
    @(posedge CLK); #1;
    expect_state("after_reset");
    checks++;
    if (DEBUG_MEM_ADDR !== 16'h0000) begin
        errors++;
        $display("FAIL direct_reset_mem_addr actual=%h required=0000", DEBUG_MEM_ADDR);
    end
    checks++;
    if (DEBUG_MEM_DATA_OUT !== 16'h0000) begin
        errors++;
        $display("FAIL direct_reset_mem_data actual=%h required=0000", DEBUG_MEM_DATA_OUT);
    end
    checks++;
    if (DEBUG_OPX !== 3'd0) begin
        errors++;
        $display("FAIL direct_reset_opx actual=%h required=0", DEBUG_OPX);
    end
    checks++;
    if (DEBUG_ARGX !== 4'd0) begin
        errors++;
        $display("FAIL direct_reset_argx actual=%h required=0", DEBUG_ARGX);
    end
    checks++;
    if (DEBUG_REQX !== 1'b0) begin
        errors++;
        $display("FAIL direct_reset_reqx actual=%b required=0", DEBUG_REQX);
    end

    host_write(3'd2, 8'h56);
    host_write(3'd1, 8'h78);
    host_write(3'd4, 8'h12);
    host_write(3'd3, 8'h34);
    host_write(3'd0, 8'h05);
    counter_pulse(1'b1, 1'b0);
    expect_state("load_5678");
    checks++;
    if (DEBUG_MEM_ADDR !== 16'h5678) begin
        errors++;
        $display("FAIL direct_load_mem_addr actual=%h required=5678", DEBUG_MEM_ADDR);
    end
    checks++;
    if (DEBUG_MEM_DATA_OUT !== 16'h1234) begin
        errors++;
        $display("FAIL direct_load_mem_data actual=%h required=1234", DEBUG_MEM_DATA_OUT);
    end
    checks++;
    if (DEBUG_OPX !== 3'd5) begin
        errors++;
        $display("FAIL direct_load_opx actual=%h required=5", DEBUG_OPX);
    end
    checks++;
    if (DEBUG_REQX !== 1'b1) begin
        errors++;
        $display("FAIL direct_load_reqx actual=%b required=1", DEBUG_REQX);
    end
    counter_pulse(1'b0, 1'b1);
    expect_state("inc_567a");
    checks++;
    if (DEBUG_MEM_ADDR !== 16'h567A) begin
        errors++;
        $display("FAIL direct_inc_mem_addr actual=%h required=567a", DEBUG_MEM_ADDR);
    end
    host_write(3'd2, 8'hFF);
    host_write(3'd1, 8'hFE);
    counter_pulse(1'b1, 1'b0);
    counter_pulse(1'b0, 1'b1);
    expect_state("wrap_0000");
    checks++;
    if (DEBUG_MEM_ADDR !== 16'h0000) begin
        errors++;
        $display("FAIL direct_wrap_mem_addr actual=%h required=0000", DEBUG_MEM_ADDR);
    end
    counter_pulse(1'b1, 1'b1);
    expect_state("ld_over_inc");
    checks++;
    if (DEBUG_MEM_ADDR !== 16'hFFFE) begin
        errors++;
        $display("FAIL direct_ld_over_inc actual=%h required=fffe", DEBUG_MEM_ADDR);
    end
    host_read(3'd1, "rd_mal");
    host_read(3'd2, "rd_mah");

    set_sources(16'hAABB, 16'hBBCC, 16'hCCDD, 16'hDDEE);
    for (int s = 0; s < 4; s++) begin
      host_write(3'd0, {4'(s + 3), 1'b0, 3'd6});
      core_pulse(1'b1, 1'b1, 2'(s));
      expect_state("capture_ack");
      host_read(3'd0, "rd_opx");
      host_read(3'd3, "rd_mdl");
      host_read(3'd4, "rd_mdh");
      core_pulse(1'b0, 1'b1, 2'd0);
      expect_state("ack_clears");
    end

    host_write_ack(3'd0, 8'h13);
    expect_state("set_beats_ack");
    checks++;
    if (DEBUG_REQX !== 1'b1) begin
        errors++;
        $display("FAIL direct_set_beats_ack actual=%b required=1", DEBUG_REQX);
    end
    host_write(3'd0, 8'h27);
    expect_state("opx_overwrite");
    host_read(3'd5, "rd_status");
    host_read(3'd6, "rd_rsvd6");

    for (int i = 0; i < 60; i++) begin
      int op;
      op = int'($urandom_range(0, 4));
      case (op)
        0: host_write(3'($urandom_range(0, 7)), 8'($urandom));
        1: host_read(3'($urandom_range(0, 7)), "rnd_read");
        2: begin
          set_sources(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
          core_pulse(1'($urandom), 1'($urandom), 2'($urandom));
        end
        3: counter_pulse(1'($urandom), 1'($urandom));
        default: expect_state("rnd_state");
      endcase
      if (i % 5 == 4) expect_state("rnd_periodic");
    end

    host_write(3'd0, 8'h21);
    RESET = 1'b0;
    model_reset();
    #1;
    checks++;
    if (DEBUG_REQX !== 1'b0) begin
        errors++;
        $display("FAIL direct_async_reset_reqx actual=%b required=0", DEBUG_REQX);
    end
    checks++;
    if (DEBUG_OPX !== 3'd0) begin
        errors++;
        $display("FAIL direct_async_reset_opx actual=%h required=0", DEBUG_OPX);
    end
    expect_state("async_reset");
    RESET = 1'b1;
    @(posedge CLK); #1;
    expect_state("post_reset");

    sync_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
